// File: rtl/sigma_delta_pkg.sv
// Shared types and helpers for the delta-sigma ADC.
//   state_e   : conversion FSM states
//   sat_count : clamps a window ones-count to the largest WIDTH-bit code
package sigma_delta_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CONVERT = 2'd2
  } state_e;

  // A window of 2^width ones yields 2^width, one past the top code.
  function automatic logic [31:0] sat_count(input logic [31:0] acc,
                                            input int unsigned width);
    logic [31:0] max_v;
    max_v = (32'd1 << width) - 32'd1;
    return (acc > max_v) ? max_v : acc;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous single-bit inputs.
//   clk, rst_n : clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronised output (second flop)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/sigma_delta_adc.sv
// Digital half of a first-order delta-sigma ADC: synchronises the comparator,
// drives the integrator feedback and counts feedback ones over 2^WIDTH-cycle
// windows, delivering one saturated WIDTH-bit sample per window.
//   clk, rst_n    : clock, async active-low reset
//   enable        : run request
//   comp_in       : raw comparator output (asynchronous)
//   fb_out        : feedback to the RC integrator
//   sample_out    : latest completed conversion
//   sample_valid  : sample_out holds an unconsumed sample
//   sample_ready  : consumer accepts when valid && ready
//   overrun       : one-cycle pulse when an unconsumed sample is overwritten
//   busy          : high in SETTLE or CONVERT
module sigma_delta_adc
  import sigma_delta_pkg::*;
#(
  parameter int unsigned WIDTH          = 10,
  parameter int unsigned SETTLE_WINDOWS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             comp_in,
  output logic             fb_out,
  output logic [WIDTH-1:0] sample_out,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned SCW = $clog2(SETTLE_WINDOWS + 1) + 1;
  localparam logic [WIDTH-1:0] CNT_LAST = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [SCW-1:0]   settle_q, settle_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             comp_sync;
  logic             win_end;
  logic             load;
  logic [WIDTH-1:0] result;

  sync_2ff u_comp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (comp_in),
    .q     (comp_sync)
  );

  // Feedback follows the synchroniser only while running; busy_q is high
  // exactly when the registered state is not IDLE.
  assign fb_out = comp_sync & busy_q;

  assign win_end = (cnt_q == CNT_LAST);
  assign result  = WIDTH'(sat_count(32'(acc_q) + 32'(fb_out), WIDTH));

  // Next-state, window counting and output register logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    settle_d  = settle_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    load      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        acc_d    = '0;
        settle_d = '0;
        if (enable) begin
          state_d = (SETTLE_WINDOWS == 0) ? CONVERT : SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + WIDTH'(1);
        acc_d = win_end ? '0 : acc_q + (WIDTH+1)'(fb_out);
        if (win_end) begin
          if (settle_q == SCW'(SETTLE_WINDOWS - 1)) begin
            state_d  = CONVERT;
            settle_d = '0;
          end else begin
            settle_d = settle_q + SCW'(1);
          end
        end
      end
      CONVERT: begin
        cnt_d = cnt_q + WIDTH'(1);
        acc_d = win_end ? '0 : acc_q + (WIDTH+1)'(fb_out);
        load  = win_end;
      end
      default: state_d = IDLE;
    endcase

    // Dropping enable abandons the partial window; a pending sample survives.
    if (state_q != IDLE && !enable) begin
      state_d  = IDLE;
      cnt_d    = '0;
      acc_d    = '0;
      settle_d = '0;
      load     = 1'b0;
    end

    if (load) begin
      sample_d  = result;
      valid_d   = 1'b1;
      overrun_d = valid_q && !sample_ready;
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      settle_q  <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      settle_q  <= settle_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sigma_delta_adc.sv
// Self-checking bench for sigma_delta_adc (WIDTH=4, SETTLE_WINDOWS=1).
// A reference model records every sampled comparator value and derives each
// window result by summing the comparator history two cycles back.
module tb_sigma_delta_adc;

  localparam int unsigned W    = 4;
  localparam int unsigned SW   = 1;
  localparam int          WIN  = 16;
  localparam int          MAXS = 15;
  localparam int          HLEN = 1024;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         comp_in;
  logic         fb_out;
  logic [W-1:0] sample_out;
  logic         sample_valid;
  logic         sample_ready;
  logic         overrun;
  logic         busy;

  int tests_run = 0;
  int fails     = 0;

  always #5 clk = ~clk;

  sigma_delta_adc #(.WIDTH(W), .SETTLE_WINDOWS(SW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .comp_in      (comp_in),
    .fb_out       (fb_out),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .busy         (busy)
  );

  // ---------------- reference model ----------------
  int           n = 0;
  bit           hist [HLEN];
  bit           running = 0;
  int           e_edge = 0;
  bit           exp_fb = 0, exp_busy = 0, exp_valid = 0, exp_ovr = 0;
  logic [W-1:0] exp_sample = '0;

  always @(posedge clk or negedge rst_n) begin : model
    bit prev;
    bit load;
    int k;
    int sum;
    if (!rst_n) begin
      running    = 0;
      exp_fb     = 0;
      exp_busy   = 0;
      exp_valid  = 0;
      exp_ovr    = 0;
      exp_sample = '0;
      hist[n % HLEN] = 0;
    end else begin
      prev = hist[n % HLEN];
      n++;
      hist[n % HLEN] = comp_in;
      load    = 0;
      exp_ovr = 0;
      if (!running) begin
        if (enable) begin
          running = 1;
          e_edge  = n;
        end
      end else if (!enable) begin
        running = 0;
      end else begin
        k = n - e_edge;
        if (k % WIN == 0 && k / WIN >= int'(SW) + 1) load = 1;
      end
      if (load) begin
        sum = 0;
        for (int j = n - WIN; j < n; j++) sum += int'(hist[(j - 1) % HLEN]);
        if (exp_valid && !sample_ready) exp_ovr = 1;
        exp_sample = (sum > MAXS) ? W'(MAXS) : W'(sum);
        exp_valid  = 1;
      end else if (exp_valid && sample_ready) begin
        exp_valid = 0;
      end
      exp_busy = running;
      exp_fb   = running ? prev : 1'b0;
    end
  end

  function automatic logic [W+3:0] got_vec();
    return {fb_out, busy, sample_valid, overrun, sample_out};
  endfunction

  function automatic logic [W+3:0] exp_vec();
    return {exp_fb, exp_busy, exp_valid, exp_ovr, exp_sample};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; comp_in = 1'b0; sample_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (got_vec() !== '0) begin
      fails++;
      $display("FAIL reset_outputs got=%h exp=%h", got_vec(), {(W+4){1'b0}});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (got_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
    end
  endtask

  // mode 0: comp=0, 1: comp=1, 2: toggle every cycle
  task automatic test_window(input int mode, input logic [W-1:0] exp_s, input string name);
    int  cyc;
    bit  seen;
    int  loads;
    enable = 1'b0; sample_ready = 1'b1;
    comp_in = (mode == 1);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    cyc = 0; seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      tests_run++;
      if (got_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL %s_cycle cyc=%0d got=%h exp=%h", name, cyc, got_vec(), exp_vec());
      end
      if (mode == 2) comp_in = ~comp_in;
      if (sample_valid) begin seen = 1; break; end
      cyc++;
    end
    tests_run++;
    if (!seen || cyc != 2 * WIN) begin
      fails++;
      $display("FAIL %s_first_valid got=%0d exp=%0d seen=%0d", name, cyc, 2 * WIN, seen);
    end
    tests_run++;
    if (sample_out !== exp_s) begin
      fails++;
      $display("FAIL %s_first_sample got=%0d exp=%0d", name, sample_out, exp_s);
    end
    loads = 0;
    for (int i = 0; i < 3 * WIN; i++) begin
      @(negedge clk);
      tests_run++;
      if (got_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL %s_run cyc=%0d got=%h exp=%h", name, i, got_vec(), exp_vec());
      end
      if (mode == 2) comp_in = ~comp_in;
      if (sample_valid) begin
        loads++;
        tests_run++;
        if (sample_out !== exp_s || i % WIN != WIN - 1) begin
          fails++;
          $display("FAIL %s_sample cyc=%0d got=%0d exp=%0d", name, i, sample_out, exp_s);
        end
      end
    end
    tests_run++;
    if (loads != 3) begin
      fails++;
      $display("FAIL %s_load_count got=%0d exp=3", name, loads);
    end
    enable = 1'b0;
  endtask

  task automatic test_random();
    enable = 1'b1;
    for (int i = 0; i < 10 * WIN; i++) begin
      comp_in      = 1'($urandom_range(0, 1));
      sample_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      tests_run++;
      if (got_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_overrun();
    int ovr;
    enable = 1'b0; sample_ready = 1'b1;
    repeat (3) @(negedge clk);
    sample_ready = 1'b0;
    enable = 1'b1;
    ovr = 0;
    for (int i = 0; i < 4 * WIN + 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (got_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL overrun_cycle cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
      if (overrun) ovr++;
      comp_in = 1'($urandom_range(0, 1));
    end
    tests_run++;
    if (ovr != 2) begin
      fails++;
      $display("FAIL overrun_count got=%0d exp=2", ovr);
    end
    tests_run++;
    if (sample_valid !== 1'b1 || sample_out !== exp_sample) begin
      fails++;
      $display("FAIL overrun_third_sample got=%0d/%0d exp=%0d/1",
               sample_out, sample_valid, exp_sample);
    end
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    tests_run++;
    if (sample_valid !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_accept got=%0d/%0d exp=0/0", sample_valid, overrun);
    end
    enable = 1'b0;
  endtask

  task automatic test_abort();
    int  cyc;
    bit  seen;
    int  vcount;
    enable = 1'b0; sample_ready = 1'b1; comp_in = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 2 * WIN + 7; i++) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || fb_out !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle got=busy%0d fb%0d exp=busy0 fb0", busy, fb_out);
    end
    vcount = 0;
    for (int i = 0; i < 3 * WIN; i++) begin
      @(negedge clk);
      if (sample_valid) vcount++;
      tests_run++;
      if (got_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL abort_hold cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
    end
    tests_run++;
    if (vcount != 0) begin
      fails++;
      $display("FAIL abort_no_sample got=%0d exp=0", vcount);
    end
    enable = 1'b1;
    cyc = 0; seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sample_valid) begin seen = 1; break; end
      cyc++;
    end
    tests_run++;
    if (!seen || cyc != 2 * WIN || sample_out !== W'(MAXS)) begin
      fails++;
      $display("FAIL abort_reenable got=%0d/%0d exp=%0d/%0d", cyc, sample_out, 2 * WIN, MAXS);
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    enable = 1'b0; sample_ready = 1'b1; comp_in = 1'b1;
    repeat (3) @(negedge clk);
    sample_ready = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 2 * WIN + 5; i++) @(negedge clk);
    tests_run++;
    if (sample_valid !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL midreset_pre got=valid%0d busy%0d exp=valid1 busy1", sample_valid, busy);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (got_vec() !== '0) begin
      fails++;
      $display("FAIL midreset_async got=%h exp=%h", got_vec(), {(W+4){1'b0}});
    end
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (got_vec() !== exp_vec() || busy !== 1'b0) begin
        fails++;
        $display("FAIL midreset_idle cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
    end
    enable = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || got_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL midreset_restart got=%h exp=%h", got_vec(), exp_vec());
    end
    enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_window(1, W'(MAXS), "full_scale");
    test_window(0, W'(0), "zero");
    test_window(2, W'(8), "toggle");
    test_random();
    test_overrun();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/sigma_delta_adc.md
# sigma_delta_adc

Digital half of a first-order delta-sigma ADC, the receive-side counterpart of the team's delta-sigma DAC. An external comparator compares the analog input against an RC integrator, and this block closes the loop. It synchronises the comparator, drives the feedback pin that charges the integrator, and counts feedback ones over fixed windows of 2^WIDTH cycles. Each window produces one WIDTH-bit unsigned sample on a valid/ready interface. Scaling matches the DAC: sample ≈ (Vin/Vref)·2^WIDTH.

## Interface
- WIDTH, 10, sample width; one conversion window = 2^WIDTH clk cycles.
- SETTLE_WINDOWS, 2, windows discarded after enable before the first delivered sample; legal range ≥0.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  run request, synchronous level.
- comp_in  in  1  raw comparator output, asynchronous to clk.
- fb_out  out  1  feedback to the RC integrator.
- sample_out  out  WIDTH  latest completed conversion.
- sample_valid  out  1  sample_out holds an unconsumed sample.
- sample_ready  in  1  consumer accepts the sample when valid&&ready.
- overrun  out  1  one-cycle pulse when an unconsumed sample is overwritten.
- busy  out  1  high in SETTLE or CONVERT.

## Operation
- comp_in passes through a 2-flop synchroniser. fb_out equals the second synchroniser flop in SETTLE and CONVERT, and is 0 in IDLE.
- State IDLE: counters held at 0.
  - enable=1 → SETTLE, or → CONVERT directly if SETTLE_WINDOWS=0.
- State SETTLE: the window counter runs; its results are discarded.
  - After SETTLE_WINDOWS complete windows → CONVERT.
- State CONVERT: runs back-to-back windows continuously.
- In any non-IDLE state, enable=0 → IDLE on the next edge. The partial window is discarded. A pending sample and sample_valid are retained until accepted.
- Window counter: WIDTH bits; the last window cycle is count == 2^WIDTH−1, then it wraps to 0.
- Ones accumulator: WIDTH+1 bits, adds fb_out every cycle of the window.
- At window end, result = acc + fb_out, range 0..2^WIDTH. Results above 2^WIDTH−1 saturate to 2^WIDTH−1.
- Output register:
  - A window end in CONVERT loads sample_out and sets sample_valid.
  - valid&&ready with no simultaneous load clears sample_valid.
  - Load in the same cycle as accept: the old sample is consumed, the new one is loaded, sample_valid stays 1, no overrun.
  - Load while valid&&!ready: sample_out is overwritten with the new sample, sample_valid stays 1, overrun pulses one cycle.
- Reset: state IDLE; synchroniser flops, counters, fb_out, sample_out, sample_valid, overrun and busy all 0.
  - Reset takes effect immediately, including mid-window.
  - Operation resumes from IDLE on the first edge after rst_n rises.

## Timing
- Edge E: the first edge sampling enable=1 in IDLE. At E the state becomes SETTLE (or CONVERT), counter = 0, busy = 1.
- sample_valid first rises at edge E + (SETTLE_WINDOWS+1)·2^WIDTH. Subsequent samples follow every 2^WIDTH cycles.
- Comparator-to-fb_out latency: 2 clk cycles.
- Comparator-to-count latency: 2 clk cycles.
- Sample register latency: 1 cycle after the last window cycle.
- overrun is asserted in the same cycle as the overwriting load.
- After enable falls: busy=0 and fb_out=0 one edge later.

## Structure
- Package sigma_delta_pkg holds:
  - the state enum (IDLE, SETTLE, CONVERT);
  - the saturation function sat_count(WIDTH+1 → WIDTH).
- Sub-module sync_2ff: a generic 2-flop synchroniser with asynchronous active-low reset, reused for comp_in.
- Everything else lives in sigma_delta_adc.

## Test plan
- WIDTH=4, SETTLE_WINDOWS=1, comp_in=1, ready=1 → first sample_valid at E+32, sample_out=15 (16 saturated), then every 16 cycles.
- comp_in=0 constant → sample_out=0 every window; fb_out=0 throughout.
- comp_in toggling every cycle, WIDTH=4 → sample_out=8 each window.
- ready=0 across 3 window ends → overrun pulses at the 2nd and 3rd ends; sample_out equals the 3rd sample. ready=1 for one cycle with no load → sample_valid drops.
- enable=0 at window cycle 7 → IDLE next edge, no sample produced, fb_out=0. Re-enable → first sample again at E'+(SETTLE_WINDOWS+1)·16.
- rst_n pulsed low mid-CONVERT with sample_valid=1 → all outputs 0 immediately. After release, stays IDLE until enable is sampled.
